fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction-fetch front end between PC generation/instruction RAM and the ID stage.
//  Owns the fetch PC and issues one word request per cycle to the instruction RAM (1-cycle read latency).
//  Buffers returned words with their PCs in a small FIFO and hands them to ID over a valid/ready handshake.
//  On a redirect from ID (jump), flushes all buffered and in-flight words and restarts fetch at jump_addr.
// PARAMETERS
//  DEPTH     4          FIFO entries; power of 2, >=2
//  RESET_PC  32'h0      fetch PC after reset
//  NOP       32'h13     instruction presented on out_inst when the queue is empty (addi x0,x0,0)
// PORTS
//  clk        in   1   clock, all state updates on posedge
//  rst        in   1   asynchronous, active-high reset
//  jump       in   1   redirect request from ID, sampled on posedge
//  jump_addr  in   32  redirect target; bits [1:0] ignored (forced 0)
//  imem_req   out  1   read request to instruction RAM this cycle
//  imem_addr  out  32  word address of the request (= fetch PC)
//  imem_rdata in   32  RAM data, valid in the cycle after the edge that sampled imem_req
//  out_valid  out  1   head entry valid for ID
//  out_ready  in   1   ID accepts head entry this cycle
//  out_inst   out  32  head instruction (NOP when empty)
//  out_pc     out  32  PC of head instruction (0 when empty)
// BEHAVIOUR
//  Reset (async, while rst=1): fetch_pc=RESET_PC, count=0, rd/wr ptr=0, inflight=0, imem_req=0,
//   out_valid=0, out_inst=NOP, out_pc=0. Any RAM response arriving after reset is discarded.
//  Credit: imem_req = !rst && !jump && (count + inflight - pop < DEPTH), pop = out_valid & out_ready.
//   imem_addr = fetch_pc; on an edge with imem_req=1: fetch_pc += 4 (wraps 0xFFFFFFFC -> 0), inflight <= 1.
//  Fill: on an edge with inflight=1 and no jump, push {imem_rdata, pc_of_request} at wr_ptr.
//   Request at edge k -> pushed at edge k+1 -> out_valid=1 after edge k+1 (2-edge fetch latency).
//  Drain: out_valid = (count != 0); out_inst/out_pc from rd_ptr entry (combinational from regs).
//   pop advances rd_ptr; push and pop in the same edge keep count unchanged, legal when full.
//  Pointers wrap modulo DEPTH; count in 0..DEPTH; never push when count==DEPTH (credit guarantees).
//  Redirect (jump=1 at an edge): count<=0, rd_ptr<=wr_ptr<=0, inflight<=0 (response next cycle dropped),
//   fetch_pc<=jump_addr&~3; imem_req=0 that cycle. Jump wins over simultaneous pop/push.
//   First redirected word on out_valid 2 edges after the jump edge.
//  jump asserted in consecutive cycles: last target wins; nothing from earlier targets is delivered.
//  out_ready while out_valid=0: ignored. imem_rdata ignored when inflight=0.
//  Order: instructions leave strictly in PC order within one redirect epoch.
// STRUCTURE
//  Shared package (cpu_pkg): XLEN=32, NOP_INST=32'h00000013, RESET_PC default.
//  One sub-module: fetch_fifo (DEPTH x 64-bit sync FIFO, push/pop/flush, count).
//  Top holds fetch_pc, inflight flag, credit logic; ~200 lines total.
// TESTING
//  1 Reset release, RAM[i]=i*4+0x100, out_ready=1 -> out_pc 0,4,8,... one per cycle from 2nd edge; out_inst matches.
//  2 out_ready=0 for 10 cycles -> exactly DEPTH entries buffered, imem_req=0 once full; release -> PCs 0..4*(DEPTH-1) in order, none lost.
//  3 jump=1, jump_addr=0x203 with full queue and request in flight -> next 2 edges out_valid=0; then out_pc=0x200, 0x204.
//  4 jump on two consecutive cycles (0x40 then 0x80) -> first delivered out_pc=0x80, no 0x40 entry ever.
//  5 fetch from RESET_PC=0xFFFFFFF8 -> out_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
//  6 rst pulsed mid-stream with request in flight -> outputs at reset values immediately; after release stream restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the fetch queue entry layout.
package cpu_pkg;
    localparam int          XLEN         = 32;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {inst, pc} entries with single-cycle flush.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);
    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          pop_ok;

    // pop on an empty queue is ignored so callers need not gate it
    assign pop_ok = pop && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, issues one RAM read per credit and buffers words for ID.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP      = NOP_INST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_addr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic            pop;
    logic [CW:0]     committed;
    logic [CW-1:0]   count;
    fetch_entry_t    head;
    fetch_entry_t    push_data;

    assign pop = out_valid && out_ready;

    // slots already promised: buffered + in flight, minus the one leaving this edge
    assign committed = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign imem_req  = !rst && !jump && (committed < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (jump) begin
            fetch_pc <= jump_addr & ~32'h3;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end
        end
    end

    assign push_data = '{inst: imem_rdata, pc: inflight_pc};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (jump),
        .push      (inflight && !jump),
        .push_data (push_data),
        .pop       (pop && !jump),
        .head      (head),
        .count     (count)
    );

    assign out_valid = (count != '0);
    assign out_inst  = out_valid ? head.inst : NOP;
    assign out_pc    = out_valid ? head.pc   : '0;
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized self-checking bench for fetch_queue against a queue-based fetch model.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump;
    logic [31:0] jump_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    logic        hi_req;
    logic [31:0] hi_addr;
    logic [31:0] hi_rdata = '0;
    logic        hi_valid;
    logic [31:0] hi_inst;
    logic [31:0] hi_pc;

    int n_cmp = 0;
    int n_mis = 0;

    // reference model state: buffered PCs, one in-flight slot, fetch PC
    logic [31:0] mq[$];
    logic        m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_fpc;
    logic [31:0] delivered[$];

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .jump(jump), .jump_addr(jump_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
    );

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_hi (
        .clk(clk), .rst(rst), .jump(1'b0), .jump_addr(32'h0),
        .imem_req(hi_req), .imem_addr(hi_addr), .imem_rdata(hi_rdata),
        .out_valid(hi_valid), .out_ready(1'b1), .out_inst(hi_inst), .out_pc(hi_pc)
    );

    // instruction RAM: word at address a holds a + 0x100
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr + 32'h100;
        if (hi_req)   hi_rdata   <= hi_addr + 32'h100;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_infl    = 1'b0;
        m_infl_pc = '0;
        m_fpc     = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_inst"},  out_inst, 32'h13);
        chk({tag, "_pc"},    out_pc, 32'h0);
        chk({tag, "_req"},   32'(imem_req), 32'd0);
    endtask

    // one cycle: called just after a negedge, returns just after the next negedge
    task automatic cycle(input logic jmp, input logic [31:0] ja, input logic rdy);
        logic pop;
        logic exp_req;
        jump = jmp; jump_addr = ja; out_ready = rdy;
        #1;
        pop     = (mq.size() != 0) && rdy;
        exp_req = !jmp && ((mq.size() + int'(m_infl) - int'(pop)) < DEPTH);
        chk("valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("pc",    out_pc,   (mq.size() != 0) ? mq[0] : 32'h0);
        chk("inst",  out_inst, (mq.size() != 0) ? mq[0] + 32'h100 : 32'h13);
        chk("req",   32'(imem_req), 32'(exp_req));
        chk("addr",  imem_addr, m_fpc);
        @(posedge clk);
        if (jmp) begin
            mq.delete();
            m_infl = 1'b0;
            m_fpc  = ja & ~32'h3;
        end else begin
            if (pop) delivered.push_back(mq.pop_front());
            if (m_infl) mq.push_back(m_infl_pc);
            m_infl = exp_req;
            if (exp_req) begin
                m_infl_pc = m_fpc;
                m_fpc     = m_fpc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int bad;
        rst = 1'b1; jump = 1'b0; jump_addr = '0; out_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_hold");
        rst = 1'b0;

        // reset release streaming, plus the high RESET_PC wrap instance
        for (int n = 0; n < 12; n++) begin
            if (n >= 2) begin
                chk("hi_valid", 32'(hi_valid), 32'd1);
                chk("hi_pc",    hi_pc, 32'hFFFF_FFF8 + 32'(4 * (n - 2)));
                chk("hi_inst",  hi_inst, 32'hFFFF_FFF8 + 32'(4 * (n - 2)) + 32'h100);
            end else begin
                chk("hi_valid_early", 32'(hi_valid), 32'd0);
            end
            cycle(1'b0, 32'h0, 1'b1);
        end

        // back-pressure: fill, then drain in order
        for (int n = 0; n < 10; n++) cycle(1'b0, 32'h0, 1'b0);
        chk("full_req_low", 32'(imem_req), 32'd0);
        delivered.delete();
        for (int n = 0; n < 8; n++) cycle(1'b0, 32'h0, 1'b1);
        for (int i = 1; i < delivered.size(); i++)
            chk("drain_order", delivered[i], delivered[i-1] + 32'd4);

        // redirect with busy queue
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h203, 1'b0);
        chk("jmp_gap0", 32'(out_valid), 32'd0);
        cycle(1'b0, 32'h0, 1'b1);
        chk("jmp_gap1", 32'(out_valid), 32'd0);
        cycle(1'b0, 32'h0, 1'b1);
        chk("jmp_first", out_pc, 32'h200);
        cycle(1'b0, 32'h0, 1'b1);
        chk("jmp_second", out_pc, 32'h204);
        cycle(1'b0, 32'h0, 1'b1);

        // back-to-back redirects: only the last target survives
        delivered.delete();
        cycle(1'b1, 32'h40, 1'b1);
        cycle(1'b1, 32'h80, 1'b1);
        for (int n = 0; n < 10; n++) cycle(1'b0, 32'h0, 1'b1);
        bad = 0;
        foreach (delivered[i]) if (delivered[i] >= 32'h40 && delivered[i] < 32'h80) bad++;
        chk("no_stale_0x40", 32'(bad), 32'd0);
        chk("first_after_dbl", (delivered.size() != 0) ? delivered[0] : 32'hDEAD_BEEF, 32'h80);

        // reset mid-stream with a request in flight
        for (int n = 0; n < 3; n++) cycle(1'b0, 32'h0, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_mid_hold");
        rst = 1'b0;
        model_reset();
        delivered.delete();
        for (int n = 0; n < 8; n++) cycle(1'b0, 32'h0, 1'b1);
        chk("restart_pc", (delivered.size() != 0) ? delivered[0] : 32'hDEAD_BEEF, 32'h0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic        j;
            logic [31:0] a;
            j = ($urandom_range(0, 15) == 0);
            a = $urandom() & 32'h0000_FFFF;
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
            cycle(j, a, 1'($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
